commit_unit: RTL and testbench



---
 rtl/commit_unit_pkg.sv | 28 ++
 rtl/commit_unit.sv | 115 +++++++++++
 tb/tb_commit_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/commit_unit_pkg.sv
// Shared types for the retirement stage: ROB entry layout, instruction type codes
// and the commit FSM state encoding.
package commit_unit_pkg;

    localparam int ROB_TAG_W = 4;
    localparam int REG_W     = 5;
    localparam int DATA_W    = 32;

    localparam logic [1:0] ITYPE_BRANCH = 2'b00;
    localparam logic [1:0] ITYPE_STORE  = 2'b01;
    localparam logic [1:0] ITYPE_LOAD   = 2'b10;
    localparam logic [1:0] ITYPE_ALU    = 2'b11;

    typedef logic [1:0] commit_state_t;
    localparam commit_state_t RUN        = 2'd0;
    localparam commit_state_t STORE_WAIT = 2'd1;
    localparam commit_state_t FLUSH      = 2'd2;

    // For branches, value carries the recovery PC captured at dispatch.
    typedef struct packed {
        logic [1:0]           itype;
        logic [ROB_TAG_W-1:0] ROB_number;
        logic [REG_W-1:0]     dest_reg;
        logic [DATA_W-1:0]    value;
        logic                 branch_result;
    } ROB_entry_t;

endpackage

// File: rtl/commit_unit.sv
// In-order retirement at the ROB head: register writes, store release handshake,
// and one-cycle flush with redirect on a mispredicted branch.
module commit_unit
    import commit_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  ROB_entry_t  head,
    input  logic        head_ready,
    input  logic        empty,
    input  logic        ROB_head_store,
    input  logic        sq_commit_ready,
    output logic        rd_en,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [3:0]  rf_wrob,
    output logic        sq_commit_valid,
    output logic [3:0]  sq_commit_rob,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] retired_count
);

    commit_state_t state_reg, state_next;
    logic [31:0]   redirect_reg, redirect_next;
    logic [31:0]   count_reg;
    logic [3:0]    store_tag_reg, store_tag_next;
    logic          head_commit;

    assign head_commit = !empty && head_ready;

    always_comb begin
        state_next      = state_reg;
        redirect_next   = redirect_reg;
        store_tag_next  = store_tag_reg;
        rd_en           = 1'b0;
        rf_we           = 1'b0;
        rf_waddr        = '0;
        rf_wdata        = '0;
        rf_wrob         = '0;
        sq_commit_valid = 1'b0;
        sq_commit_rob   = '0;
        flush           = 1'b0;

        // Everything below is suppressed while reset is held so no strobe escapes.
        if (!reset) begin
            rf_waddr      = head.dest_reg;
            rf_wdata      = head.value;
            rf_wrob       = head.ROB_number;
            sq_commit_rob = head.ROB_number;

            case (state_reg)
                RUN: begin
                    if (head_commit) begin
                        if (head.itype[1]) begin
                            rd_en = 1'b1;
                            rf_we = (head.dest_reg != '0);
                        end else if (ROB_head_store) begin
                            sq_commit_valid = 1'b1;
                            store_tag_next  = head.ROB_number;
                            if (sq_commit_ready) begin
                                rd_en = 1'b1;
                            end else begin
                                state_next = STORE_WAIT;
                            end
                        end else if (head.itype == ITYPE_BRANCH) begin
                            rd_en = 1'b1;
                            if (head.branch_result) begin
                                redirect_next = head.value;
                                state_next    = FLUSH;
                            end
                        end
                    end
                end
                STORE_WAIT: begin
                    // The head is already known complete; only the queue gates retirement.
                    sq_commit_valid = 1'b1;
                    sq_commit_rob   = store_tag_reg;
                    if (sq_commit_ready) begin
                        rd_en      = 1'b1;
                        state_next = RUN;
                    end
                end
                FLUSH: begin
                    flush      = 1'b1;
                    state_next = RUN;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    assign redirect_pc   = reset ? 32'd0 : redirect_reg;
    assign retired_count = reset ? 32'd0 : count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RUN;
            redirect_reg  <= '0;
            store_tag_reg <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            redirect_reg  <= redirect_next;
            store_tag_reg <= store_tag_next;
            if (rd_en) begin
                count_reg <= count_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
// Randomized plus directed bench for commit_unit: a program-order scoreboard of
// expected retirement effects checked by an independent negedge monitor.
module tb_commit_unit;
    import commit_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    ROB_entry_t  head;
    logic        head_ready, empty, ROB_head_store, sq_commit_ready;
    logic        rd_en, rf_we, sq_commit_valid, flush;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, redirect_pc, retired_count;
    logic [3:0]  rf_wrob, sq_commit_rob;

    commit_unit dut (
        .clk(clk), .reset(reset), .head(head), .head_ready(head_ready),
        .empty(empty), .ROB_head_store(ROB_head_store),
        .sq_commit_ready(sq_commit_ready), .rd_en(rd_en), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wrob(rf_wrob),
        .sq_commit_valid(sq_commit_valid), .sq_commit_rob(sq_commit_rob),
        .flush(flush), .redirect_pc(redirect_pc), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  tag;
        bit          is_store;
        bit          mispredict;
        logic [31:0] pc;
    } exp_t;

    ROB_entry_t rob_q[$];
    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    bit         deq_seen = 1'b0;

    // Monitor-side view of the architectural rules
    bit          store_wait_m = 1'b0;
    logic [3:0]  store_tag_m = '0;
    bit          flush_due = 1'b0;
    logic [31:0] pc_due = '0;
    logic [31:0] n_ret = '0;
    bit          exp_rd, exp_sqv, commit_run, next_flush;
    logic [3:0]  exp_tag;
    exp_t        x;

    function automatic exp_t expect_of(input ROB_entry_t e);
        exp_t r;
        r.we         = e.itype[1] && (e.dest_reg != 5'd0);
        r.waddr      = e.dest_reg;
        r.wdata      = e.value;
        r.tag        = e.ROB_number;
        r.is_store   = (e.itype == ITYPE_STORE);
        r.mispredict = (e.itype == ITYPE_BRANCH) && e.branch_result;
        r.pc         = e.value;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, expv);
        end
    endtask

    task automatic push(input logic [1:0] it, input logic [3:0] tag, input logic [4:0] dest,
                        input logic [31:0] val, input bit br);
        ROB_entry_t e;
        e.itype = it; e.ROB_number = tag; e.dest_reg = dest; e.value = val; e.branch_result = br;
        rob_q.push_back(e);
        exp_q.push_back(expect_of(e));
    endtask

    task automatic cycle(input bit rdy, input bit sqr, input bit femp, input bit rst);
        ROB_entry_t dummy;
        @(posedge clk);
        #1;
        if (deq_seen && rob_q.size() > 0) dummy = rob_q.pop_front();
        reset = rst;
        if (rst) begin
            rob_q.delete();
            exp_q.delete();
        end
        if (rob_q.size() > 0) head = rob_q[0];
        head_ready      = rdy;
        sq_commit_ready = sqr;
        empty           = femp || (rob_q.size() == 0);
        ROB_head_store  = (head.itype == ITYPE_STORE);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_strobes", {28'd0, rd_en, rf_we, sq_commit_valid, flush}, 32'd0);
            chk("reset_outs", {rf_wdata ^ redirect_pc}, 32'd0);
            chk("reset_count", retired_count, 32'd0);
            store_wait_m = 1'b0;
            flush_due    = 1'b0;
            n_ret        = '0;
            deq_seen     = 1'b0;
        end else begin
            commit_run = !flush_due && !store_wait_m && !empty && head_ready;
            if (flush_due)         exp_rd = 1'b0;
            else if (store_wait_m) exp_rd = sq_commit_ready;
            else if (commit_run)   exp_rd = ROB_head_store ? sq_commit_ready : 1'b1;
            else                   exp_rd = 1'b0;
            exp_sqv = !flush_due && (store_wait_m || (commit_run && ROB_head_store));
            exp_tag = store_wait_m ? store_tag_m : head.ROB_number;

            chk("retired_count", retired_count, n_ret);
            chk("rd_en", {31'd0, rd_en}, {31'd0, exp_rd});
            chk("sq_commit_valid", {31'd0, sq_commit_valid}, {31'd0, exp_sqv});
            if (exp_sqv) chk("sq_commit_rob", {28'd0, sq_commit_rob}, {28'd0, exp_tag});
            chk("flush", {31'd0, flush}, {31'd0, flush_due});
            if (flush_due) chk("redirect_pc", redirect_pc, pc_due);

            next_flush = 1'b0;
            if (rd_en) begin
                if (exp_q.size() == 0) begin
                    chk("retire_without_entry", 32'd1, 32'd0);
                end else begin
                    x = exp_q.pop_front();
                    chk("rf_we", {31'd0, rf_we}, {31'd0, x.we});
                    if (x.we) begin
                        chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, x.waddr});
                        chk("rf_wdata", rf_wdata, x.wdata);
                        chk("rf_wrob", {28'd0, rf_wrob}, {28'd0, x.tag});
                    end
                    if (x.is_store) chk("store_release", {31'd0, sq_commit_valid}, 32'd1);
                    $display("retire t=%0t tag=%0d we=%0b waddr=%0d wdata=%h store=%0b mispredict=%0b",
                             $time, x.tag, x.we, x.waddr, x.wdata, x.is_store, x.mispredict);
                    if (x.mispredict) begin
                        next_flush = 1'b1;
                        pc_due     = x.pc;
                    end
                end
            end else begin
                chk("rf_we_idle", {31'd0, rf_we}, 32'd0);
            end

            store_wait_m = exp_sqv && !sq_commit_ready;
            if (exp_sqv) store_tag_m = exp_tag;
            flush_due = next_flush;
            if (exp_rd) n_ret = n_ret + 32'd1;
            deq_seen = rd_en;
        end
    end

    initial begin
        reset = 1'b1; head = '0; head_ready = 1'b0; empty = 1'b1;
        ROB_head_store = 1'b0; sq_commit_ready = 1'b0;
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);

        // ALU write, then a dest_reg==0 ALU that must not write
        push(ITYPE_ALU, 4'd3, 5'd5, 32'hDEADBEEF, 1'b0);
        cycle(1, 0, 0, 0);
        push(ITYPE_ALU, 4'd4, 5'd0, 32'h12345678, 1'b0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);

        // Store tag 7 with the queue stalling three cycles
        push(ITYPE_STORE, 4'd7, 5'd0, 32'h0, 1'b0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // Mispredict followed by a ready ALU head
        push(ITYPE_BRANCH, 4'd8, 5'd0, 32'h00400080, 1'b1);
        push(ITYPE_ALU, 4'd9, 5'd12, 32'hCAFEF00D, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);

        // Empty overrides a stale ready head
        push(ITYPE_LOAD, 4'd10, 5'd3, 32'h55AA55AA, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Reset while waiting on the store queue
        push(ITYPE_STORE, 4'd11, 5'd0, 32'h0, 1'b0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            if (rob_q.size() < 6 && ($urandom % 2 == 0)) begin
                push(2'($urandom % 4), 4'(1 + $urandom % 15), 5'($urandom % 32),
                     $urandom, ($urandom % 4 == 0));
            end
            cycle(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 10) == 0, 0);
        end
        for (int i = 0; i < 30; i++) cycle(1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
